postfix_evaluator: RTL and testbench

POSTFIX_EVALUATOR -- requirements
Module: postfix_evaluator

---
 rtl/eval_pkg.sv | 24 ++
 rtl/eval_stack.sv | 52 +++++
 rtl/postfix_evaluator.sv | 118 +++++++++++
 tb/tb_postfix_evaluator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/eval_pkg.sv
// Shared constants and types for the postfix evaluator: character codes,
// result status codes, FSM states and the latched operator.
package eval_pkg;

  localparam logic [7:0] CH_NUL   = 8'd0;
  localparam logic [7:0] CH_PLUS  = 8'd43;
  localparam logic [7:0] CH_MINUS = 8'd45;
  localparam logic [7:0] CH_MUL   = 8'd42;
  localparam logic [7:0] CH_ZERO  = 8'd48;
  localparam logic [7:0] CH_NINE  = 8'd57;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_BAD   = 2'd3;

  typedef enum logic [1:0] {RUN, EXEC, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_ZERO) && (c <= CH_NINE);
  endfunction

endpackage

// File: rtl/eval_stack.sv
// Register-based operand LIFO: push at sp, or replace the top two entries
// with one result (write at sp-2, sp-1). Only sp is reset; contents persist.
module eval_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             wr2,
  input  logic [WIDTH-1:0] wr2_data,
  input  logic             clr,
  output logic [SPW-1:0]   sp,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] nxt
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SPW-1:0]   sp_reg;
  logic [AW-1:0]    push_idx, top_idx, nxt_idx;

  // Indices wrap when sp is too small; the controller never uses those reads.
  assign push_idx = AW'(sp_reg);
  assign top_idx  = AW'(sp_reg - SPW'(1));
  assign nxt_idx  = AW'(sp_reg - SPW'(2));

  assign sp  = sp_reg;
  assign top = mem[top_idx];
  assign nxt = mem[nxt_idx];

  always_ff @(posedge clk) begin
    if (push)
      mem[push_idx] <= push_data;
    else if (wr2)
      mem[nxt_idx] <= wr2_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sp_reg <= '0;
    else if (clr)
      sp_reg <= '0;
    else if (push)
      sp_reg <= sp_reg + SPW'(1);
    else if (wr2)
      sp_reg <= sp_reg - SPW'(1);
  end

endmodule

// File: rtl/postfix_evaluator.sv
// Streaming postfix (RPN) evaluator over single decimal digits with + - *,
// terminated by NUL; one result/status per expression with a ready handshake.
module postfix_evaluator
  import eval_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_err,
  input  logic             res_ready
);
  localparam int SPW = $clog2(DEPTH + 1);

  state_t           state;
  op_t              op_reg;
  logic [SPW-1:0]   sp;
  logic [WIDTH-1:0] top, nxt, alu, digit_val;
  logic [7:0]       digit_off;
  logic             accept, push, wr2, clr;
  logic             term, go_exec;
  logic [1:0]       term_err;
  op_t              op_next;

  assign in_ready  = (state == RUN);
  assign res_valid = (state == DONE);
  assign accept    = in_valid && (state == RUN);

  assign digit_off = in_char - CH_ZERO;
  assign digit_val = WIDTH'(digit_off);

  // Classify the offered character; only acted upon when accept is high.
  always_comb begin
    term     = 1'b0;
    term_err = ERR_OK;
    go_exec  = 1'b0;
    op_next  = OP_ADD;
    if (is_digit(in_char)) begin
      if (sp == SPW'(DEPTH)) begin
        term     = 1'b1;
        term_err = ERR_OVER;
      end
    end else if (in_char == CH_PLUS || in_char == CH_MINUS || in_char == CH_MUL) begin
      op_next = (in_char == CH_PLUS)  ? OP_ADD :
                (in_char == CH_MINUS) ? OP_SUB : OP_MUL;
      if (sp >= SPW'(2)) begin
        go_exec = 1'b1;
      end else begin
        term     = 1'b1;
        term_err = ERR_UNDER;
      end
    end else if (in_char == CH_NUL) begin
      term     = 1'b1;
      term_err = (sp == SPW'(1)) ? ERR_OK :
                 (sp == '0)      ? ERR_UNDER : ERR_BAD;
    end else begin
      term     = 1'b1;
      term_err = ERR_BAD;
    end
  end

  always_comb begin
    case (op_reg)
      OP_ADD:  alu = nxt + top;
      OP_SUB:  alu = nxt - top;
      default: alu = nxt * top;
    endcase
  end

  assign push = accept && is_digit(in_char) && !term;
  assign wr2  = (state == EXEC);
  assign clr  = (state == DONE) && res_ready;

  eval_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SPW(SPW)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (digit_val),
    .wr2       (wr2),
    .wr2_data  (alu),
    .clr       (clr),
    .sp        (sp),
    .top       (top),
    .nxt       (nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      op_reg   <= OP_ADD;
      res_data <= '0;
      res_err  <= ERR_OK;
    end else begin
      case (state)
        RUN: begin
          if (accept && term) begin
            res_data <= (term_err == ERR_OK) ? top : '0;
            res_err  <= term_err;
            state    <= DONE;
          end else if (accept && go_exec) begin
            op_reg <= op_next;
            state  <= EXEC;
          end
        end
        EXEC:    state <= RUN;
        DONE:    if (res_ready) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_postfix_evaluator.sv
// Directed bench for postfix_evaluator: a queue-based RPN model predicts each
// result, and a negedge compare process checks outputs while a result is held.
module tb_postfix_evaluator;
  localparam int DEPTH = 16;
  localparam int WIDTH = 16;

  typedef logic [7:0] bq_t[$];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [7:0]       in_char = 8'd0;
  logic             in_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       res_err;
  logic             res_ready = 1'b0;

  int               n_vec = 0;
  int               n_bad = 0;
  bit               exp_armed = 1'b0;
  logic [WIDTH-1:0] exp_data = '0;
  logic [1:0]       exp_err = '0;

  postfix_evaluator #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_err   (res_err),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic bq_t mk(input string s, input bit term);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    if (term) q.push_back(8'd0);
    return q;
  endfunction

  // Plain RPN evaluation on an integer queue, stopping at the first terminal event.
  function automatic void model(input bq_t s, output logic [WIDTH-1:0] d,
                                output logic [1:0] e, output int ex);
    longint st[$];
    longint a, b, r;
    d = '0; e = 2'd0; ex = 0;
    for (int i = 0; i < s.size(); i++) begin
      logic [7:0] c;
      c = s[i];
      if (c >= 8'd48 && c <= 8'd57) begin
        if (st.size() == DEPTH) begin e = 2'd2; return; end
        st.push_back(longint'(c) - 48);
      end else if (c == 8'd43 || c == 8'd45 || c == 8'd42) begin
        if (st.size() < 2) begin e = 2'd1; return; end
        b = st.pop_back();
        a = st.pop_back();
        r = (c == 8'd43) ? a + b : (c == 8'd45) ? a - b : a * b;
        st.push_back(r & 64'hFFFF);
        ex++;
      end else if (c == 8'd0) begin
        if (st.size() == 1) d = WIDTH'(st[0]);
        else e = (st.size() == 0) ? 2'd1 : 2'd3;
        return;
      end else begin
        e = 2'd3;
        return;
      end
    end
  endfunction

  // Feed a character stream with in_valid held high until a result appears
  // or the stream is exhausted; counts in_ready-low cycles on the way.
  task automatic run_stream(input bq_t s, output int execs, output bit got);
    int   idx = 0;
    logic rdy;
    execs = 0;
    got   = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      in_valid = (idx < s.size());
      in_char  = (idx < s.size()) ? s[idx] : 8'd0;
      @(negedge clk);
      rdy = in_ready;
      if (!rdy) execs++;
      @(posedge clk);
      #1;
      if (in_valid && rdy) idx++;
      if (res_valid) begin got = 1'b1; break; end
      if (idx >= s.size() && in_ready) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic take_result();
    exp_armed = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("in_ready after take", in_ready, 1);
    check("res_valid after take", res_valid, 0);
  endtask

  task automatic run_case(input string s, input bit term, input logic [WIDTH-1:0] d,
                          input logic [1:0] e, input int hold);
    bq_t              q;
    logic [WIDTH-1:0] md;
    logic [1:0]       me;
    int               mex, execs;
    bit               got;
    q = mk(s, term);
    model(q, md, me, mex);
    run_stream(q, execs, got);
    check({"'", s, "' result seen"}, got, 1);
    check({"'", s, "' data"}, res_data, d);
    check({"'", s, "' err"}, res_err, e);
    check({"'", s, "' exec cycles"}, execs, mex);
    exp_data  = md;
    exp_err   = me;
    exp_armed = 1'b1;
    // Offer a digit while the result is held: it must not be consumed.
    in_valid = (hold > 0);
    in_char  = 8'd57;
    repeat (hold + 1) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    take_result();
    $display("expr '%s'%s -> data %0h err %0d", s, term ? "+NUL" : "", res_data, res_err);
  endtask

  always @(negedge clk) begin
    if (exp_armed && !rst) begin
      check("held res_valid", res_valid, 1);
      check("held res_data", res_data, exp_data);
      check("held res_err", res_err, exp_err);
      check("in_ready in DONE", in_ready, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  execs;
    bit  got;

    #12;
    check("reset res_valid", res_valid, 0);
    check("reset res_data", res_data, 0);
    check("reset res_err", res_err, 0);
    check("reset in_ready", in_ready, 1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    run_case("23+4*",             1'b1, 16'd20,   2'd0, 0);
    run_case("35-",               1'b1, 16'hFFFE, 2'd0, 5);
    run_case("7",                 1'b1, 16'd7,    2'd0, 0);
    run_case("99*9*9*9*",         1'b1, 16'hE6A9, 2'd0, 0);
    run_case("+",                 1'b0, 16'd0,    2'd1, 0);
    run_case("11111111111111111", 1'b0, 16'd0,    2'd2, 0);
    run_case("12",                1'b1, 16'd0,    2'd3, 0);
    run_case("1a",                1'b0, 16'd0,    2'd3, 0);
    run_case("",                  1'b1, 16'd0,    2'd1, 0);
    run_case("1+",                1'b0, 16'd0,    2'd1, 0);
    run_case("8765+-*",           1'b1, 16'hFFE0, 2'd0, 0);

    // Asynchronous reset while a result is held in DONE.
    run_stream(mk("9", 1'b1), execs, got);
    check("'9' before reset data", res_data, 9);
    #2 rst = 1'b1;
    #1;
    check("async rst in DONE res_valid", res_valid, 0);
    check("async rst in DONE res_data", res_data, 0);
    check("async rst in DONE in_ready", in_ready, 1);
    $display("async reset in DONE -> valid %0d data %0h", res_valid, res_data);
    #1 rst = 1'b0;

    // Asynchronous reset mid-expression: partial stack must be discarded.
    run_stream(mk("12", 1'b0), execs, got);
    check("'12' no result", got, 0);
    #2 rst = 1'b1;
    #1;
    check("async rst mid res_valid", res_valid, 0);
    check("async rst mid res_err", res_err, 0);
    check("async rst mid in_ready", in_ready, 1);
    $display("async reset mid-expression -> valid %0d ready %0d", res_valid, in_ready);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    run_case("4", 1'b1, 16'd4, 2'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
